// File: rtl/ram_dump.sv
// Read-back engine for the 512x8 data-path RAM: streams a wrapping address range out over
// valid/ready with address and last flag, and reports an 8-bit additive checksum at the end.
module ram_dump #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 8
) (
  input  logic              main_clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [DATA_W-1:0] ram_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last
);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StCapt,
    StSend,
    StDone
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic [ADDR_W-1:0] ram_addr_q, out_addr_q;
  logic [DATA_W-1:0] out_data_q;
  logic              busy_q, done_q, ram_rd_q, out_valid_q, out_last_q;
  logic              hs;

  // Values committed on a handshake; the address counter wraps naturally at 2**ADDR_W.
  always_comb begin
    hs     = out_valid_q & out_ready;
    addr_d = addr_q + ADDR_W'(1);
    rem_d  = rem_q - (ADDR_W + 1)'(1);
    sum_d  = sum_q + out_data_q;
  end

  always_ff @(posedge main_clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      rem_q       <= '0;
      sum_q       <= '0;
      ram_addr_q  <= '0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ram_rd_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      ram_rd_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            addr_q <= start_addr;
            rem_q  <= length;
            sum_q  <= '0;
            busy_q <= 1'b1;
            if (length == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q    <= StReq;
              ram_rd_q   <= 1'b1;
              ram_addr_q <= start_addr;
            end
          end
        end
        StReq: begin
          if (abort) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else begin
            state_q <= StCapt;
          end
        end
        StCapt: begin
          if (abort) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else begin
            out_data_q  <= ram_data;
            out_addr_q  <= addr_q;
            out_last_q  <= (rem_q == (ADDR_W + 1)'(1));
            out_valid_q <= 1'b1;
            state_q     <= StSend;
          end
        end
        StSend: begin
          // Abort wins over a simultaneous handshake: the byte is dropped, not counted.
          if (abort) begin
            out_valid_q <= 1'b0;
            state_q     <= StDone;
            done_q      <= 1'b1;
          end else if (hs) begin
            out_valid_q <= 1'b0;
            sum_q       <= sum_d;
            rem_q       <= rem_d;
            addr_q      <= addr_d;
            if (rem_d != '0) begin
              state_q    <= StReq;
              ram_rd_q   <= 1'b1;
              ram_addr_q <= addr_d;
            end else begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    busy      = busy_q;
    done      = done_q;
    checksum  = sum_q;
    ram_addr  = ram_addr_q;
    ram_rd    = ram_rd_q;
    out_valid = out_valid_q;
    out_data  = out_data_q;
    out_addr  = out_addr_q;
    out_last  = out_last_q;
  end

endmodule

// File: tb/tb_ram_dump.sv
// Bench for ram_dump: a queue-based stream model checked every cycle, plus directed
// latency/checksum expectations computed by hand.
module tb_ram_dump;

  logic       main_clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [8:0] start_addr = '0;
  logic [9:0] length = '0;
  logic       abort = 1'b0;
  logic       busy, done, ram_rd, out_valid, out_ready, out_last;
  logic [7:0] checksum, out_data;
  logic [7:0] ram_data = '0;
  logic [8:0] ram_addr, out_addr;

  ram_dump #(.ADDR_W(9), .DATA_W(8)) dut (
    .main_clk  (main_clk),
    .reset     (reset),
    .start     (start),
    .start_addr(start_addr),
    .length    (length),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .checksum  (checksum),
    .ram_addr  (ram_addr),
    .ram_rd    (ram_rd),
    .ram_data  (ram_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_last  (out_last)
  );

  always #5 main_clk = ~main_clk;

  logic [7:0] mem [0:511];
  always @(posedge main_clk) if (ram_rd) ram_data <= mem[ram_addr];

  // Consumer: either a fixed ready level or a repeating 1-0-0-1 pattern.
  logic       ready_lvl = 1'b1;
  logic       bp_en = 1'b0;
  logic       bp_r = 1'b1;
  logic [3:0] bp_pat = 4'b1001;
  int         bp_idx = 0;
  assign out_ready = bp_en ? bp_r : ready_lvl;
  always @(posedge main_clk) begin
    #1;
    if (bp_en) begin
      bp_r   = bp_pat[bp_idx];
      bp_idx = (bp_idx + 1) % 4;
    end
  end

  typedef struct packed {
    logic [8:0] a;
    logic [7:0] d;
    logic       l;
  } beat_t;

  beat_t      exp_q[$];
  logic [7:0] model_sum = '0;
  bit         model_active = 1'b0;
  int         tests = 0, errors = 0;
  int         hs_cnt = 0, rd_cnt = 0, stall_cnt = 0, done_cnt = 0;
  logic [8:0] last_hs_addr = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Per-cycle compare against the stream model.
  bit         prev_v = 1'b0, prev_hs = 1'b0;
  logic [7:0] prev_d;
  logic [8:0] prev_a;
  logic       prev_l;
  always @(negedge main_clk) begin
    bit hs;
    if (!reset) begin
      exp_q.delete();
      model_active = 1'b0;
      prev_v = 1'b0;
    end else begin
      chk("busy", 32'(busy), 32'(model_active));
      if (out_valid) begin
        if (exp_q.size() == 0) chk("extra_beat", 32'(1), 32'(0));
        else begin
          chk("out_data", 32'(out_data), 32'(exp_q[0].d));
          chk("out_addr", 32'(out_addr), 32'(exp_q[0].a));
          chk("out_last", 32'(out_last), 32'(exp_q[0].l));
        end
        if (prev_v && !prev_hs) begin
          stall_cnt++;
          chk("stall_data", 32'(out_data), 32'(prev_d));
          chk("stall_addr", 32'(out_addr), 32'(prev_a));
          chk("stall_last", 32'(out_last), 32'(prev_l));
        end
      end
      if (ram_rd) begin
        rd_cnt++;
        if (exp_q.size() > 0) chk("ram_addr", 32'(ram_addr), 32'(exp_q[0].a));
      end
      hs = out_valid && out_ready && !abort;
      if (hs && exp_q.size() > 0) begin
        model_sum    = model_sum + exp_q[0].d;
        last_hs_addr = exp_q[0].a;
        void'(exp_q.pop_front());
        hs_cnt++;
      end
      if (done) begin
        done_cnt++;
        chk("checksum", 32'(checksum), 32'(model_sum));
        model_active = 1'b0;
        exp_q.delete();
      end else if (abort && model_active) begin
        exp_q.delete();
      end
      prev_v  = out_valid;
      prev_hs = hs;
      prev_d  = out_data;
      prev_a  = out_addr;
      prev_l  = out_last;
    end
  end

  // Called at posedge+1 while idle; returns at T+1 where T is the accepting edge.
  task automatic do_start(input logic [8:0] a, input logic [9:0] len);
    exp_q.delete();
    for (int k = 0; k < int'(len); k++) begin
      beat_t b;
      b.a = 9'((int'(a) + k) % 512);
      b.d = mem[b.a];
      b.l = (k == int'(len) - 1);
      exp_q.push_back(b);
    end
    model_sum  = '0;
    start_addr = a;
    length     = len;
    start      = 1'b1;
    @(posedge main_clk);
    model_active = 1'b1;
    #1 start = 1'b0;
  endtask

  // n = 1 means done during the first cycle after the call; returns in the following IDLE.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge main_clk);
      n++;
    end while (!done && n < 3000);
    if (!done) chk("done_timeout", 32'(0), 32'(1));
    @(posedge main_clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ctl"}, 32'({busy, done, ram_rd, out_valid, out_last}), 32'(0));
    chk({tag, "_addr"}, 32'({ram_addr, out_addr}), 32'(0));
    chk({tag, "_data"}, 32'({out_data, checksum}), 32'(0));
  endtask

  initial begin
    int n, h0, r0, s0, d0;
    for (int i = 0; i < 512; i++) mem[i] = 8'((i * 7 + 3) % 256);
    repeat (3) @(posedge main_clk);
    #1 chk_reset_vals("rst");
    reset = 1'b1;
    @(posedge main_clk);
    #1;

    // Full range: sum of (7i+3) over 0..511 is 0 mod 256.
    h0 = hs_cnt;
    do_start(9'd100, 10'd512);
    wait_done(n);
    chk("full_cycles", 32'(n), 32'(1537));
    chk("full_hs", 32'(hs_cnt - h0), 32'(512));
    chk("full_last_addr", 32'(last_hs_addr), 32'(99));
    chk("full_sum", 32'(checksum), 32'(0));

    mem[50] = 8'h00; mem[51] = 8'h00; mem[52] = 8'h00; mem[53] = 8'h05;
    mem[510] = 8'hFF; mem[511] = 8'h80; mem[0] = 8'h81;
    mem[200] = 8'h11; mem[201] = 8'h22; mem[202] = 8'h33; mem[203] = 8'h44;

    h0 = hs_cnt; r0 = rd_cnt;
    do_start(9'd50, 10'd4);
    wait_done(n);
    chk("basic_cycles", 32'(n), 32'(13));
    chk("basic_sum", 32'(checksum), 32'(5));
    chk("basic_hs", 32'(hs_cnt - h0), 32'(4));
    chk("basic_rd", 32'(rd_cnt - r0), 32'(4));
    chk("basic_last_addr", 32'(last_hs_addr), 32'(53));

    r0 = rd_cnt;
    do_start(9'd7, 10'd0);
    wait_done(n);
    chk("len0_cycles", 32'(n), 32'(1));
    chk("len0_sum", 32'(checksum), 32'(0));
    chk("len0_rd", 32'(rd_cnt - r0), 32'(0));

    h0 = hs_cnt; s0 = stall_cnt;
    bp_idx = 0;
    bp_en  = 1'b1;
    do_start(9'd50, 10'd4);
    wait_done(n);
    bp_en = 1'b0;
    chk("bp_hs", 32'(hs_cnt - h0), 32'(4));
    chk("bp_sum", 32'(checksum), 32'(5));
    chk("bp_stalled", 32'(stall_cnt > s0), 32'(1));

    do_start(9'd510, 10'd3);
    wait_done(n);
    chk("wrap_cycles", 32'(n), 32'(10));
    chk("wrap_sum", 32'(checksum), 32'(0));
    chk("wrap_last_addr", 32'(last_hs_addr), 32'(0));

    // Abort during the second byte's SEND with ready high.
    h0 = hs_cnt;
    do_start(9'd200, 10'd4);
    repeat (5) @(posedge main_clk);
    #1 abort = 1'b1;
    @(negedge main_clk);
    chk("abort_valid", 32'(out_valid), 32'(1));
    chk("abort_addr", 32'(out_addr), 32'(201));
    @(posedge main_clk);
    #1 abort = 1'b0;
    @(negedge main_clk);
    chk("abort_done", 32'(done), 32'(1));
    chk("abort_sum", 32'(checksum), 32'(8'h11));
    chk("abort_hs", 32'(hs_cnt - h0), 32'(1));
    @(posedge main_clk);
    #1;
    do_start(9'd201, 10'd2);
    wait_done(n);
    chk("post_abort_cycles", 32'(n), 32'(7));
    chk("post_abort_sum", 32'(checksum), 32'(8'h55));

    // Reset during SEND of the first byte, then an immediate start.
    do_start(9'd200, 10'd4);
    repeat (2) @(posedge main_clk);
    #1 chk("pre_rst_valid", 32'(out_valid), 32'(1));
    reset = 1'b0;
    @(posedge main_clk);
    #1 chk_reset_vals("mid_rst");
    reset = 1'b1;
    d0 = done_cnt;
    do_start(9'd200, 10'd4);
    wait_done(n);
    chk("rst_restart_cycles", 32'(n), 32'(13));
    chk("rst_restart_sum", 32'(checksum), 32'(8'hAA));
    chk("rst_no_extra_done", 32'(done_cnt - d0), 32'(1));

    // A start pulse while busy must be ignored.
    h0 = hs_cnt;
    do_start(9'd200, 10'd4);
    @(posedge main_clk);
    @(posedge main_clk);
    #1 start_addr = 9'd0;
    length = 10'd1;
    start  = 1'b1;
    @(posedge main_clk);
    #1 start = 1'b0;
    wait_done(n);
    chk("busy_start_cycles", 32'(n), 32'(10));
    chk("busy_start_sum", 32'(checksum), 32'(8'hAA));
    chk("busy_start_hs", 32'(hs_cnt - h0), 32'(4));
    repeat (3) @(negedge main_clk);
    chk("idle_after", 32'(busy), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/ram_dump.md
# ram_dump

Memory read-back engine for the data path's 512 × 8 RAM. On command it reads a contiguous, wrapping address range through the RAM's read port. It streams each byte out over a valid/ready interface with its address and a last flag, and reports an 8-bit additive checksum when the range is finished. It is the read-side counterpart of program loading: once a run completes, it lets the bench or host pull program and data memory (for example result words at 50–53) back out.

## Interface
- `ADDR_W`, 9: RAM address width.
- `DATA_W`, 8: RAM data width.
- `main_clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  begin a dump; sampled only in IDLE.
- `start_addr`  in  ADDR_W  first address to read; captured on accepted `start`.
- `length`  in  ADDR_W+1  number of bytes to read, 0..512; captured on accepted `start`.
- `abort`  in  1  cancel the dump in progress.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when a dump ends (normally, by abort, or for length 0).
- `checksum`  out  DATA_W  sum mod 256 of all bytes handed off in the last dump.
- `ram_addr`  out  ADDR_W  RAM read address.
- `ram_rd`  out  1  RAM read strobe.
- `ram_data`  in  DATA_W  RAM read data, valid in the cycle after `ram_rd`.
- `out_valid`  out  1  `out_data`, `out_addr` and `out_last` are valid.
- `out_ready`  in  1  consumer accepts the byte.
- `out_data`  out  DATA_W  byte read from RAM.
- `out_addr`  out  ADDR_W  address the byte came from.
- `out_last`  out  1  this is the final byte of the dump.

## Operation
- States: IDLE, REQ, CAPT, SEND, DONE.
- IDLE:
  - On `start`=1, capture `start_addr` into the address counter and `length` into the remaining-count register, and clear the checksum.
  - If `length`=0, go to DONE; otherwise go to REQ.
- REQ: drive `ram_rd`=1 and `ram_addr`=address counter. Go to CAPT.
- CAPT:
  - Latch `ram_data` into `out_data` and the address counter into `out_addr`.
  - Set `out_last` = (remaining == 1).
  - Go to SEND.
- SEND:
  - Hold `out_valid`=1 with the data stable until `out_valid && out_ready`.
  - On the handshake edge: add `out_data` to the checksum (8-bit wrap), decrement remaining, and increment the address counter modulo 512 (511 → 0).
  - Then go to REQ if remaining is still nonzero, else to DONE.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- `abort`=1 in REQ, CAPT or SEND:
  - Go to DONE next cycle with no further handshake, even if `out_ready` is high in that same SEND cycle.
  - The checksum covers only bytes already accepted.
- `abort` in IDLE or DONE is ignored.
- `start` while `busy` is ignored. `start` in the DONE cycle is also ignored.
- Outputs outside their valid windows:
  - `ram_rd` is 0 outside REQ.
  - `ram_addr` holds its last value.
  - `out_valid` is 0 outside SEND.
  - `out_data`, `out_addr` and `out_last` hold their last latched values.
- `checksum` holds from DONE until the next accepted `start`.

## Timing
- Reset (`reset`=0 at an edge) forces the following, from any state, including mid-dump:
  - state = IDLE
  - `busy`, `done`, `ram_rd`, `out_valid` and `out_last` = 0
  - `ram_addr`, `out_addr`, `out_data` and `checksum` = 0
  - remaining = 0
- A dump aborted by reset produces no `done` pulse.
- `start` accepted at edge T:
  - REQ during cycle T+1.
  - CAPT during T+2.
  - First `out_valid` during T+3.
- With `out_ready` held high, each byte takes 3 cycles (REQ, CAPT, SEND). Byte k is valid during T+3+3k.
- The cycle after the final handshake is DONE, so `done` and the final `checksum` appear together.
- A length-0 start at edge T gives `done` during T+1, `checksum`=0, and no `ram_rd`.
- Backpressure stretches SEND by any number of cycles, with all stream outputs stable.
- `busy` is high from T+1 through the DONE cycle inclusive.

## Test plan
- Basic dump: mem[50..53] = 0, 0, 0, 5; `start_addr`=50, `length`=4, `out_ready`=1.
  - Four bytes 0, 0, 0, 5 at addresses 50–53, with `out_last` only on 53.
  - `done` at T+13; `checksum`=5.
- Backpressure: same range, `out_ready` toggled 1-0-0-1 per cycle.
  - Identical byte sequence.
  - `out_data`/`out_addr` never change while `out_valid`=1 and `out_ready`=0.
  - Exactly 4 handshakes.
- Wrap and width: mem[510]=0xFF, mem[511]=0x80, mem[0]=0x81; `start_addr`=510, `length`=3.
  - Addresses 510, 511, 0; `checksum`=0x00 (mod-256 wrap).
- Length 0, and full length 512:
  - 0 gives `done` at T+1, no `ram_rd`.
  - 512 gives 512 handshakes, ending at address `start_addr`-1 mod 512.
- Abort mid-SEND of the second byte, with `out_ready`=1 in the same cycle.
  - That byte is not counted; `done` the next cycle.
  - `checksum` = the first byte only.
  - A later `start` works normally.
- Reset in SEND: drive `reset`=0 for one edge.
  - All outputs go to their reset values with no `done`.
  - `start` ignored while `busy`; `start` right after reset is accepted.
